// File: rtl/cache_flush_pkg.sv
// cache_flush_pkg: shared widths, walker state type and line-address builder
package cache_flush_pkg;
  localparam int S_INDEX_DEF  = 4;
  localparam int S_TAG_DEF    = 23;
  localparam int S_OFFSET_DEF = 5;
  typedef enum logic [2:0] {IDLE, SCAN, WB, CLEAR, DONE} flush_state_t;
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                            input int s_index, input int s_offset);
    return (tag << (s_index + s_offset)) | (index << s_offset);
  endfunction
endpackage

// File: rtl/cache_flush_walker.sv
// cache_flush_walker: walks all sets on flush, writes back valid+dirty lines, clears dirty (CACHE_FLUSH_INVALIDATE_EN also invalidates)
module cache_flush_walker
  import cache_flush_pkg::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_TAG    = S_TAG_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [S_INDEX-1:0] arr_index,
  input  logic               valid_in,
  input  logic               dirty_in,
  input  logic [S_TAG-1:0]   tag_in,
  output logic               dirty_load,
  output logic               dirty_datain,
  output logic               valid_load,
  output logic               valid_datain,
  output logic               wb_req,
  output logic [31:0]        wb_addr,
  input  logic               wb_ack
);
  flush_state_t       state, state_n;
  logic [S_INDEX-1:0] idx, idx_n;
  logic [31:0]        addr_n;
  logic               last;
  assign last         = &idx;
  assign arr_index    = idx;
  assign flush_busy   = state != IDLE;
  assign flush_done   = state == DONE;
  assign wb_req       = state == WB;
  assign dirty_load   = state == CLEAR;
  assign dirty_datain = 1'b0;
  assign valid_datain = 1'b0;
`ifdef CACHE_FLUSH_INVALIDATE_EN
  assign valid_load   = state == CLEAR;
`else
  assign valid_load   = 1'b0;
`endif
  // state, index and latched writeback address
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      wb_addr <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      wb_addr <= addr_n;
    end
  end
  // next state: scan sets in order, detour through WB/CLEAR for lines needing maintenance
  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = wb_addr;
    case (state)
      IDLE: begin
        state_n = flush_req ? SCAN : IDLE;
        idx_n   = '0;
      end
      SCAN: begin
        if (valid_in && dirty_in) begin
          state_n = WB;
          addr_n  = line_addr(32'(tag_in), 32'(idx), S_INDEX, S_OFFSET);
        end
`ifdef CACHE_FLUSH_INVALIDATE_EN
        else if (valid_in) state_n = CLEAR;
`endif
        else if (last) state_n = DONE;
        else idx_n = idx + 1'b1;
      end
      WB: state_n = wb_ack ? CLEAR : WB;
      CLEAR: begin
        state_n = last ? DONE : SCAN;
        idx_n   = last ? idx : idx + 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_flush_walker.sv
// tb_cache_flush_walker: directed checks of the flush walker against a modelled metadata array
module tb_cache_flush_walker;
  logic        clk = 0, rst = 1, flush_req = 0, wb_ack = 0;
  logic        flush_busy, flush_done, dirty_load, dirty_datain, valid_load, valid_datain, wb_req;
  logic [3:0]  arr_index;
  logic [31:0] wb_addr;
  logic [15:0] valid_arr, dirty_arr, set_valid = 0, set_dirty = 0;
  logic        load_meta = 0;
  logic [22:0] tag_arr [16];
  int n_checks = 0, n_errors = 0, ack_delay = 1;
  int wb_n = 0, wb_cyc = 0, unstable = 0, clr_n = 0, clr_after_ack = 0, vl_n = 0, done_n = 0, busy_n = 0;
  int wb_log [32];
  int clr_log [32];
  logic        prev_req = 0, prev_ack = 0;
  logic [31:0] prev_addr = 0;

  cache_flush_walker dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .arr_index(arr_index), .valid_in(valid_arr[arr_index]), .dirty_in(dirty_arr[arr_index]),
    .tag_in(tag_arr[arr_index]), .dirty_load(dirty_load), .dirty_datain(dirty_datain),
    .valid_load(valid_load), .valid_datain(valid_datain), .wb_req(wb_req), .wb_addr(wb_addr),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_meta) begin
      valid_arr <= set_valid;
      dirty_arr <= set_dirty;
    end else begin
      if (dirty_load) dirty_arr[arr_index] <= dirty_datain;
      if (valid_load) valid_arr[arr_index] <= valid_datain;
    end
  end

  always @(negedge clk) begin
    if (wb_req && wb_ack) begin
      wb_log[wb_n % 32] <= int'(wb_addr);
      wb_n <= wb_n + 1;
    end
    if (wb_req) wb_cyc <= wb_cyc + 1;
    if (wb_req && prev_req && wb_addr !== prev_addr) unstable <= unstable + 1;
    if (dirty_load) begin
      clr_log[clr_n % 32] <= int'(arr_index);
      clr_n <= clr_n + 1;
      if (prev_ack) clr_after_ack <= clr_after_ack + 1;
    end
    if (valid_load) vl_n <= vl_n + 1;
    if (flush_done) done_n <= done_n + 1;
    if (flush_busy && !flush_done) busy_n <= busy_n + 1;
    prev_req  <= wb_req;
    prev_addr <= wb_addr;
    prev_ack  <= wb_req && wb_ack;
  end

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_req) begin
        cnt++;
        wb_ack = cnt >= ack_delay;
      end else begin
        cnt = 0;
        wb_ack = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [15:0] d);
    set_valid = v;
    set_dirty = d;
    load_meta = 1;
    @(posedge clk);
    #1 load_meta = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!flush_done && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic run_flush(output int cyc);
    flush_req = 1;
    @(posedge clk);
    #1 flush_req = 0;
    wait_done(cyc);
  endtask

  initial begin
    int c, b_wb, b_clr, b_ca, b_vl, b_done, b_busy, b_cyc, b_uns, nv;
    logic [31:0] a0, a1;
    for (int i = 0; i < 16; i++) tag_arr[i] = 23'(i * 3 + 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_index", arr_index, 0);
    check("rst_wb_req", wb_req, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_dirty_load", dirty_load, 0);
    check("rst_valid_load", valid_load, 0);
    rst = 0;
    // clean cache; set 5 has dirty without valid, which must be skipped
    load(16'h0000, 16'h0020);
    b_wb = wb_n; b_clr = clr_n; b_busy = busy_n;
    run_flush(c);
    check("clean_done_cycle", c + 1, 17);
    #4;
    check("clean_busy_cycles", busy_n - b_busy, 16);
    check("clean_no_wb", wb_n - b_wb, 0);
    check("clean_no_clear", clr_n - b_clr, 0);
    check("clean_dirty5_kept", dirty_arr[5], 1);
    @(posedge clk); #1;
    check("clean_idle_busy", flush_busy, 0);
    // set 3 dirty, ack after 4 cycles
    tag_arr[3] = 23'h1ABCD;
    load(16'h0008, 16'h0008);
    ack_delay = 4;
    b_wb = wb_n; b_clr = clr_n; b_ca = clr_after_ack; b_cyc = wb_cyc; b_uns = unstable;
    run_flush(c);
    check("d3_done_cycle", c + 1, 22);
    #4;
    check("d3_wb_count", wb_n - b_wb, 1);
    check("d3_wb_addr", wb_log[b_wb % 32], (32'h1ABCD << 9) | (32'd3 << 5));
    check("d3_wb_req_cycles", wb_cyc - b_cyc, 4);
    check("d3_addr_stable", unstable - b_uns, 0);
    check("d3_clear_count", clr_n - b_clr, 1);
    check("d3_clear_index", clr_log[b_clr % 32], 3);
    check("d3_clear_after_ack", clr_after_ack - b_ca, 1);
    check("d3_dirty_cleared", dirty_arr[3], 0);
    @(posedge clk); #1;
    // sets 0 and 15 dirty, fast ack
    tag_arr[0] = 23'h11;
    tag_arr[15] = 23'h7FFFFF;
    load(16'h8001, 16'h8001);
    ack_delay = 1;
    b_wb = wb_n; b_clr = clr_n;
    run_flush(c);
    check("edge_done_cycle", c + 1, 21);
    #4;
    a0 = (32'h11 << 9);
    a1 = (32'h7FFFFF << 9) | (32'd15 << 5);
    check("edge_wb_count", wb_n - b_wb, 2);
    check("edge_wb_first", wb_log[b_wb % 32], a0);
    check("edge_wb_second", wb_log[(b_wb + 1) % 32], a1);
    check("edge_clear_count", clr_n - b_clr, 2);
    check("edge_clear_first", clr_log[b_clr % 32], 0);
    check("edge_clear_last", clr_log[(b_clr + 1) % 32], 15);
    check("edge_dirty_bits", dirty_arr, 0);
    @(posedge clk); #1;
    check("edge_idle_index", arr_index, 0);
    check("edge_idle_busy", flush_busy, 0);
    // reset while writing back set 7
    tag_arr[7] = 23'h2222;
    load(16'h0080, 16'h0080);
    ack_delay = 1000;
    b_done = done_n; b_clr = clr_n;
    flush_req = 1;
    @(posedge clk);
    #1 flush_req = 0;
    c = 0;
    while (!wb_req && c < 40) begin
      @(posedge clk);
      #1 c++;
    end
    check("rstwb_reached_wb", wb_req, 1);
    check("rstwb_index", arr_index, 7);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("rstwb_busy", flush_busy, 0);
    check("rstwb_wb_req", wb_req, 0);
    check("rstwb_wb_addr", wb_addr, 0);
    check("rstwb_index0", arr_index, 0);
    rst = 0;
    repeat (30) @(posedge clk);
    #1;
    check("rstwb_no_done", done_n - b_done, 0);
    check("rstwb_no_clear", clr_n - b_clr, 0);
    check("rstwb_dirty7_kept", dirty_arr[7], 1);
    ack_delay = 1;
    // held flush_req re-triggers once per pass
    load(16'h0000, 16'h0000);
    b_done = done_n;
    flush_req = 1;
    wait_done(c);
    check("held_first_done", c, 17);
    @(posedge clk); #1;
    check("held_idle_gap", flush_busy, 0);
    @(posedge clk); #1;
    check("held_restart", flush_busy, 1);
    wait_done(c);
    check("held_second_done", c, 16);
    flush_req = 0;
    repeat (3) @(posedge clk);
    #1;
    check("held_stopped", flush_busy, 0);
    check("held_done_pulses", done_n - b_done, 2);
    // four valid lines, one dirty
    load(16'h1224, 16'h0200);
    b_wb = wb_n; b_vl = vl_n;
    run_flush(c);
    #4;
    nv = 0;
    for (int i = 0; i < 16; i++) nv += int'(valid_arr[i]);
    check("inv_wb_count", wb_n - b_wb, 1);
    check("inv_dirty_bits", dirty_arr, 0);
`ifdef CACHE_FLUSH_INVALIDATE_EN
    check("inv_done_cycle", c + 1, 22);
    check("inv_valid_loads", vl_n - b_vl, 4);
    check("inv_valid_left", nv, 0);
`else
    check("inv_done_cycle", c + 1, 19);
    check("inv_valid_loads", vl_n - b_vl, 0);
    check("inv_valid_left", nv, 4);
`endif
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
